// File: rtl/nr_div_pkg.sv
// nr_div_pkg: FSM state type and legal WIDTH limits shared by the non-restoring divider files.
// Used by nonrestoring_divider (optional signed mode: SIGNED_DIV_EN) and nr_div_step.
package nr_div_pkg;

    localparam int NR_DIV_MIN_WIDTH = 2;
    localparam int NR_DIV_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } nr_div_state_e;

    // Evaluated at elaboration by the top to reject unsupported WIDTH values.
    function automatic bit nr_div_width_ok(input int width);
        return (width >= NR_DIV_MIN_WIDTH) && (width <= NR_DIV_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// nr_div_step: one combinational non-restoring iteration on the {A,Qr} pair.
// A is WIDTH+1 bits two's complement; Mr is an unsigned WIDTH-bit divisor magnitude.
module nr_div_step
    import nr_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] qr_i,
    input  logic [WIDTH-1:0] mr_i,
    output logic [WIDTH:0]   a_next_o,
    output logic [WIDTH-1:0] qr_next_o
);

    logic [WIDTH:0] a_shift_s;
    logic [WIDTH:0] mr_ext_s;

    // Shift, then add or subtract; the pre-shift sign of A selects the operation because
    // the shifted intermediate may wrap in WIDTH+1 bits while the final A never does.
    always_comb begin
        a_shift_s = {a_i[WIDTH-1:0], qr_i[WIDTH-1]};
        mr_ext_s  = {1'b0, mr_i};
        if (a_i[WIDTH] == 1'b0) begin
            a_next_o = a_shift_s - mr_ext_s;
        end else begin
            a_next_o = a_shift_s + mr_ext_s;
        end
        qr_next_o = {qr_i[WIDTH-2:0], ~a_next_o[WIDTH]};
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider: WIDTH-generic multi-cycle non-restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN to add the sgn port and two's complement operation.
module nonrestoring_divider
    import nr_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remain,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (!nr_div_width_ok(WIDTH)) begin : g_width_check
        $error("nonrestoring_divider: WIDTH %0d outside %0d..%0d", WIDTH, NR_DIV_MIN_WIDTH, NR_DIV_MAX_WIDTH);
    end

    nr_div_state_e      state_q;
    logic [WIDTH:0]     a_q;
    logic [WIDTH-1:0]   qr_q;
    logic [WIDTH-1:0]   mr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_q;
    logic               dbz_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   q_mag_d;
    logic [WIDTH-1:0]   m_mag_d;
    logic [WIDTH:0]     a_step_d;
    logic [WIDTH-1:0]   qr_step_d;
    logic [WIDTH:0]     a_fix_d;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_d;

`ifdef SIGNED_DIV_EN
    logic               neg_q_q;
    logic               neg_r_q;
    logic               neg_q_d;
    logic               neg_r_d;

    // Operand magnitudes and result sign flags captured on the accepting edge.
    always_comb begin
        q_mag_d = dividend;
        m_mag_d = divisor;
        neg_q_d = 1'b0;
        neg_r_d = 1'b0;
        if (sgn) begin
            if (dividend[WIDTH-1]) begin
                q_mag_d = -dividend;
            end else begin
                q_mag_d = dividend;
            end
            if (divisor[WIDTH-1]) begin
                m_mag_d = -divisor;
            end else begin
                m_mag_d = divisor;
            end
            neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_d = dividend[WIDTH-1];
        end else begin
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
        end
    end
`else
    // Unsigned build: magnitudes are the raw operands.
    always_comb begin
        q_mag_d = dividend;
        m_mag_d = divisor;
    end
`endif

    nr_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i       (a_q),
        .qr_i      (qr_q),
        .mr_i      (mr_q),
        .a_next_o  (a_step_d),
        .qr_next_o (qr_step_d)
    );

    // Final remainder restore and (optionally) sign correction of both results.
    always_comb begin
        if (a_q[WIDTH]) begin
            a_fix_d = a_q + {1'b0, mr_q};
        end else begin
            a_fix_d = a_q;
        end
        quot_d = qr_q;
        rem_d  = a_fix_d[WIDTH-1:0];
`ifdef SIGNED_DIV_EN
        if (neg_q_q) begin
            quot_d = -qr_q;
        end else begin
            quot_d = qr_q;
        end
        if (neg_r_q) begin
            rem_d = -a_fix_d[WIDTH-1:0];
        end else begin
            rem_d = a_fix_d[WIDTH-1:0];
        end
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            mr_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            a_q     <= '0;
                            qr_q    <= q_mag_d;
                            mr_q    <= m_mag_d;
                            cnt_q   <= CNT_W'(WIDTH);
`ifdef SIGNED_DIV_EN
                            neg_q_q <= neg_q_d;
                            neg_r_q <= neg_r_d;
`endif
                            state_q <= ITER;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ITER: begin
                    a_q   <= a_step_d;
                    qr_q  <= qr_step_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end else begin
                        state_q <= ITER;
                    end
                end
                FIX: begin
                    quot_q  <= quot_d;
                    rem_q   <= rem_d;
                    dbz_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // Divide-by-zero enters with done low and spends one cycle raising it.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remain      = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb_nonrestoring_divider: table-driven directed checks of the 4- and 8-bit dividers plus
// hand-written sequences for held start, mid-operation reset and divide-by-zero.
module tb_nonrestoring_divider;

    typedef struct {
        bit         use8;
        logic [7:0] dvd;
        logic [7:0] dvs;
        bit         sg;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        bit         exp_dbz;
        int         exp_lat;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic [3:0] dvd4 = 4'h0;
    logic [3:0] dvs4 = 4'h0;
    logic       busy4, done4, dbz4;
    logic [3:0] q4, r4;
    logic       start8 = 1'b0;
    logic [7:0] dvd8 = 8'h00;
    logic [7:0] dvs8 = 8'h00;
    logic       busy8, done8, dbz8;
    logic [7:0] q8, r8;
`ifdef SIGNED_DIV_EN
    logic       sgn4 = 1'b0;
    logic       sgn8 = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    nonrestoring_divider #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .dividend    (dvd4),
        .divisor     (dvs4),
`ifdef SIGNED_DIV_EN
        .sgn         (sgn4),
`endif
        .busy        (busy4),
        .done        (done4),
        .quotient    (q4),
        .remain      (r4),
        .div_by_zero (dbz4)
    );

    nonrestoring_divider #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dvd8),
        .divisor     (dvs8),
`ifdef SIGNED_DIV_EN
        .sgn         (sgn8),
`endif
        .busy        (busy8),
        .done        (done8),
        .quotient    (q8),
        .remain      (r8),
        .div_by_zero (dbz8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit use8, input bit st, input logic [7:0] a, input logic [7:0] b, input bit sg);
        if (use8) begin
            start8 = st;
            dvd8   = a;
            dvs8   = b;
`ifdef SIGNED_DIV_EN
            sgn8   = sg;
`endif
        end else begin
            start4 = st;
            dvd4   = a[3:0];
            dvs4   = b[3:0];
`ifdef SIGNED_DIV_EN
            sgn4   = sg;
`endif
        end
    endtask

    function automatic logic cur_busy(input bit use8);
        return use8 ? busy8 : busy4;
    endfunction

    function automatic logic cur_done(input bit use8);
        return use8 ? done8 : done4;
    endfunction

    function automatic logic [7:0] cur_q(input bit use8);
        return use8 ? q8 : {4'h0, q4};
    endfunction

    function automatic logic [7:0] cur_r(input bit use8);
        return use8 ? r8 : {4'h0, r4};
    endfunction

    function automatic logic cur_dbz(input bit use8);
        return use8 ? dbz8 : dbz4;
    endfunction

    // Starts one operation from an IDLE cycle and checks latency, busy, results and done width.
    task automatic run_op(input vec_t v);
        int cyc;
        bit busy_ok;
        drive(v.use8, 1'b1, v.dvd, v.dvs, v.sg);
        @(posedge clk); #1;
        drive(v.use8, 1'b0, 8'h00, 8'h00, 1'b0);
        busy_ok = (cur_busy(v.use8) === 1'b1);
        cyc = 0;
        while (cyc < 40 && cur_done(v.use8) !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
            if (cur_busy(v.use8) !== 1'b1) busy_ok = 1'b0;
        end
        check({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
        check({v.name, " busy"}, 32'(busy_ok), 32'd1);
        check({v.name, " quotient"}, 32'(cur_q(v.use8)), 32'(v.exp_q));
        check({v.name, " remain"}, 32'(cur_r(v.use8)), 32'(v.exp_r));
        check({v.name, " div_by_zero"}, 32'(cur_dbz(v.use8)), 32'(v.exp_dbz));
        @(posedge clk); #1;
        check({v.name, " done one cycle"}, 32'(cur_done(v.use8)), 32'd0);
        check({v.name, " busy released"}, 32'(cur_busy(v.use8)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen;
        vec_t v;

        vecs.push_back('{1'b0, 8'd15, 8'd11, 1'b0, 8'd1, 8'd4, 1'b0, 5, "w4 15/11"});
        vecs.push_back('{1'b0, 8'd15, 8'd3, 1'b0, 8'd5, 8'd0, 1'b0, 5, "w4 15/3"});
        vecs.push_back('{1'b0, 8'd11, 8'd3, 1'b0, 8'd3, 8'd2, 1'b0, 5, "w4 11/3"});
        vecs.push_back('{1'b0, 8'd12, 8'd4, 1'b0, 8'd3, 8'd0, 1'b0, 5, "w4 12/4"});
        vecs.push_back('{1'b1, 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 9, "w8 200/7"});
        vecs.push_back('{1'b1, 8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, 9, "w8 255/1"});
        vecs.push_back('{1'b1, 8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0, 9, "w8 5/9"});
        vecs.push_back('{1'b1, 8'd77, 8'd0, 1'b0, 8'hFF, 8'd77, 1'b1, 1, "w8 77/0"});
        vecs.push_back('{1'b1, 8'd10, 8'd2, 1'b0, 8'd5, 8'd0, 1'b0, 9, "w8 10/2"});
`ifdef SIGNED_DIV_EN
        vecs.push_back('{1'b1, 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9, "s8 -7/2"});
        vecs.push_back('{1'b1, 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 9, "s8 7/-2"});
        vecs.push_back('{1'b1, 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9, "s8 -128/-1"});
        vecs.push_back('{1'b1, 8'hF7, 8'h00, 1'b1, 8'hFF, 8'hF7, 1'b1, 1, "s8 -9/0"});
        vecs.push_back('{1'b1, 8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 1'b0, 9, "u8 249/2"});
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset done8", 32'(done8), 32'd0);
        check("reset quotient8", 32'(q8), 32'd0);
        check("reset remain8", 32'(r8), 32'd0);
        check("reset dbz8", 32'(dbz8), 32'd0);
        check("reset busy4", 32'(busy4), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // start held high; operands change mid-ITER and must not disturb the running divide
        drive(1'b1, 1'b1, 8'd100, 8'd7, 1'b0);
        @(posedge clk); #1;
        cyc = 0;
        while (cyc < 40 && done8 !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) drive(1'b1, 1'b1, 8'd50, 8'd5, 1'b0);
        end
        check("held latency", 32'(cyc), 32'd9);
        check("held quotient", 32'(q8), 32'd14);
        check("held remain", 32'(r8), 32'd2);
        @(posedge clk); #1;
        check("held idle busy", 32'(busy8), 32'd0);
        check("held idle done", 32'(done8), 32'd0);
        cyc = 0;
        while (cyc < 40 && done8 !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held second latency", 32'(cyc), 32'd10);
        check("held second quotient", 32'(q8), 32'd10);
        check("held second remain", 32'(r8), 32'd0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("held second done cleared", 32'(done8), 32'd0);

        // reset at E4 of an 8-bit divide abandons it without a done pulse
        drive(1'b1, 1'b1, 8'd200, 8'd7, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy", 32'(busy8), 32'd0);
        check("midrst done", 32'(done8), 32'd0);
        check("midrst quotient", 32'(q8), 32'd0);
        check("midrst remain", 32'(r8), 32'd0);
        check("midrst dbz", 32'(dbz8), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
        end
        check("midrst no done", 32'(seen), 32'd0);
        v = '{1'b1, 8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0, 9, "w8 100/10 after reset"};
        run_op(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
